acc_unary_unit: RTL
===================

Name: acc_unary_unit

Overview:
- Parametrised, multi-cycle accumulator unary-operation unit: the next-generation replacement for the fixed 8-bit CMA/INR/DCR path in the CPU datapath.
- Holds its own WIDTH-bit accumulator and Z/N/C flags.
- Executes complement, increment, decrement and clear, plus rotate/shift ops by a run-time count, one bit position per clock.
- Sits beside the ALU in u_cpu; the control unit drives it through a start/busy/done handshake.

Parameters:
- WIDTH, 8, accumulator and data width (legal 4..32).
- CNT_W, 4, width of the shift/rotate count input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- load_i  input  1  load accumulator from load_data_i.
- load_data_i  input  WIDTH  load value.
- start_i  input  1  request execution of op_i.
- op_i  input  4  operation code; values listed under Behaviour.
- count_i  input  CNT_W  step count for rotate/shift ops; ignored by single-step ops.
- busy_o  output  1  unit is executing (states EXEC and DONE).
- done_o  output  1  one-cycle completion pulse.
- illegal_o  output  1  one-cycle pulse when an undefined opcode is accepted.
- acc_o  output  WIDTH  accumulator value.
- flag_zero_o  output  1  Z flag.
- flag_negative_o  output  1  N flag (acc MSB).
- flag_carry_o  output  1  C flag.

Behaviour:
- Reset (asynchronous, while reset=0):
  - acc_o=0, Z=1, N=0, C=0.
  - busy_o=0, done_o=0, illegal_o=0, state=IDLE.
  - Reset mid-operation aborts immediately and discards the partial result.
- Op encoding: 0 NOP, 1 CMA, 2 INR, 3 DCR, 4 CLR, 5 RLC, 6 RRC, 7 RAL, 8 RAR, 9 SHL, 10 SHR; 11-15 illegal.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE:
    - load_i=1: acc<=load_data_i and Z/N update from the loaded value; C unaffected. Load has priority; a simultaneous start_i is dropped.
    - Otherwise start_i=1: latch op and count (remaining = count_i for shift ops, 1 for others), go to EXEC.
  - EXEC: one step per cycle; remaining decrements each cycle.
    - Leave to DONE on the cycle where the final step is applied.
    - count_i=0 on a shift op: exactly one EXEC cycle, acc and all flags unchanged.
  - DONE: done_o=1 for exactly this cycle, then IDLE.
  - load_i and start_i are ignored whenever busy_o=1.
- Latency: single-step ops complete in 1 EXEC cycle, so done_o is high 2 cycles after the start edge. Shift ops with count N>0 take N EXEC cycles, so done_o is high N+1 cycles after the start edge.
- Step semantics (W=WIDTH):
  - CMA: acc<=~acc; Z, N, C all unaffected.
  - INR / DCR: acc<=acc±1 modulo 2^W (wraps); Z/N updated; C unaffected.
  - CLR: acc<=0; Z=1, N=0, C=0.
  - RLC / RRC: rotate by 1 without carry; C<=the bit rotated out.
  - RAL / RAR: rotate through C, i.e. a (W+1)-bit rotation.
  - SHL / SHR: logical shift with 0 fill; C<=bit shifted out.
  - Shift-class Z/N are updated once, from the final acc value, in the last EXEC cycle.
  - Count values larger than W are legal and simply keep rotating/shifting.
  - NOP: no state change; still reports done_o.
  - Illegal opcode: behaves as NOP; illegal_o pulses in the DONE cycle alongside done_o.
- acc_o and all flag outputs are registered and change only on clock edges (or on reset).

Decomposition:
- Add to arch_defs_pkg:
  - typedef enum logic [3:0] acc_op_t for the op encodings;
  - typedef enum for FSM states IDLE/EXEC/DONE;
  - constants ACC_OP_FIRST_ILLEGAL=11 and ACC_DEFAULT_WIDTH=8.
- One natural sub-module: acc_step_logic. It is purely combinational: inputs op, acc and C; outputs next acc and carry-out for a single step. It is instantiated once and reused every EXEC cycle.

Test Plan:
- WIDTH=8: load 0xAA -> acc=0xAA, N=1, Z=0. Then start CMA -> done_o on the 2nd cycle after start; acc=0x55, N stays 1 (flags unaffected).
- WIDTH=8: load 0x81, C=0 after reset; start RAL with count=3.
  - Per-cycle acc/C during EXEC: 0x02/1, 0x05/0, 0x0A/0.
  - busy_o high for 4 cycles; done_o on the 4th cycle after start; final Z=0, N=0.
- WIDTH=8: load 0xFF, then INR -> acc=0x00, Z=1, N=0, C unchanged. Then DCR -> acc=0xFF, N=1.
- Start RRC count=5 from 0x01; assert reset (low) during the 2nd EXEC cycle -> immediately acc=0, Z=1, C=0, busy_o=0, and no done_o pulse.
- WIDTH=16: load 0x00FF (N=0), CMA -> acc=0xFF00, N stays 0. Then SHR count=0 -> acc=0xFF00, flags unchanged, done_o after 1 EXEC cycle.
- Pulse start_i together with load_i in IDLE -> load applied, no EXEC. Then op=13 -> illegal_o and done_o pulse together; acc unchanged.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the accumulator unary-operation unit.
// Provides the op encoding, FSM state type, flag payload struct and
// op-classification helpers used by acc_unary_unit and acc_step_logic.
package arch_defs_pkg;

  localparam int unsigned ACC_DEFAULT_WIDTH    = 8;
  localparam int unsigned ACC_OP_W             = 4;
  localparam int unsigned ACC_OP_FIRST_ILLEGAL = 11;

  // Operation encodings; 11..15 are undefined and execute as NOP.
  typedef enum logic [ACC_OP_W-1:0] {
    ACC_OP_NOP = 4'd0,
    ACC_OP_CMA = 4'd1,
    ACC_OP_INR = 4'd2,
    ACC_OP_DCR = 4'd3,
    ACC_OP_CLR = 4'd4,
    ACC_OP_RLC = 4'd5,
    ACC_OP_RRC = 4'd6,
    ACC_OP_RAL = 4'd7,
    ACC_OP_RAR = 4'd8,
    ACC_OP_SHL = 4'd9,
    ACC_OP_SHR = 4'd10
  } acc_op_t;

  typedef enum logic [1:0] {
    ACC_ST_IDLE = 2'd0,
    ACC_ST_EXEC = 2'd1,
    ACC_ST_DONE = 2'd2
  } acc_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
  } acc_flags_t;

  // Rotate/shift ops run for a count taken from count_i.
  function automatic logic acc_op_is_shift(input logic [ACC_OP_W-1:0] op);
    return (op >= ACC_OP_RLC) && (op <= ACC_OP_SHR);
  endfunction

  function automatic logic acc_op_is_illegal(input logic [ACC_OP_W-1:0] op);
    return op >= ACC_OP_W'(ACC_OP_FIRST_ILLEGAL);
  endfunction

  // Ops whose result drives Z/N (shift class only on its final step).
  function automatic logic acc_op_updates_zn(input logic [ACC_OP_W-1:0] op);
    return (op == ACC_OP_INR) || (op == ACC_OP_DCR) || (op == ACC_OP_CLR) ||
           acc_op_is_shift(op);
  endfunction

endpackage

// File: rtl/acc_step_logic.sv
// Single-step combinational datapath for the accumulator unit.
// Ports:
//   op           - operation code (acc_op_t encoding, illegal codes pass through)
//   acc          - current accumulator
//   carry        - current C flag
//   next_acc_c   - accumulator after one step
//   carry_out_c  - C flag after one step (unchanged for ops that ignore C)
module acc_step_logic
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_DEFAULT_WIDTH
) (
  input  logic [ACC_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    acc,
  input  logic                carry,
  output logic [WIDTH-1:0]    next_acc_c,
  output logic                carry_out_c
);

  // One bit position per invocation; RAL/RAR treat {C, acc} as a W+1 ring.
  always_comb begin
    next_acc_c  = acc;
    carry_out_c = carry;
    case (op)
      ACC_OP_CMA: next_acc_c = ~acc;
      ACC_OP_INR: next_acc_c = acc + WIDTH'(1);
      ACC_OP_DCR: next_acc_c = acc - WIDTH'(1);
      ACC_OP_CLR: begin
        next_acc_c  = '0;
        carry_out_c = 1'b0;
      end
      ACC_OP_RLC: begin
        next_acc_c  = {acc[WIDTH-2:0], acc[WIDTH-1]};
        carry_out_c = acc[WIDTH-1];
      end
      ACC_OP_RRC: begin
        next_acc_c  = {acc[0], acc[WIDTH-1:1]};
        carry_out_c = acc[0];
      end
      ACC_OP_RAL: begin
        next_acc_c  = {acc[WIDTH-2:0], carry};
        carry_out_c = acc[WIDTH-1];
      end
      ACC_OP_RAR: begin
        next_acc_c  = {carry, acc[WIDTH-1:1]};
        carry_out_c = acc[0];
      end
      ACC_OP_SHL: begin
        next_acc_c  = {acc[WIDTH-2:0], 1'b0};
        carry_out_c = acc[WIDTH-1];
      end
      ACC_OP_SHR: begin
        next_acc_c  = {1'b0, acc[WIDTH-1:1]};
        carry_out_c = acc[0];
      end
      default: begin
        next_acc_c  = acc;
        carry_out_c = carry;
      end
    endcase
  end

endmodule

// File: rtl/acc_unary_unit.sv
// Multi-cycle accumulator unary-operation unit with its own accumulator and
// Z/N/C flags. Single-step ops take one EXEC cycle; rotate/shift ops take
// count_i EXEC cycles (one bit per cycle), or one no-op cycle when count_i=0.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   load_i/load_data_i - load accumulator (IDLE only, wins over start_i)
//   start_i/op_i/count_i - start an operation (IDLE only)
//   busy_o             - executing (EXEC or DONE)
//   done_o, illegal_o  - one-cycle completion / undefined-opcode pulses
//   acc_o, flag_*_o    - registered accumulator and flags
module acc_unary_unit
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_data_i,
  input  logic                start_i,
  input  logic [ACC_OP_W-1:0] op_i,
  input  logic [CNT_W-1:0]    count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic [WIDTH-1:0]    acc_o,
  output logic                flag_zero_o,
  output logic                flag_negative_o,
  output logic                flag_carry_o
);

  acc_state_t          state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  acc_flags_t          flags_q, flags_d;
  logic [ACC_OP_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic [WIDTH-1:0]    step_acc_c;
  logic                step_carry_c;

  acc_step_logic #(
    .WIDTH (WIDTH)
  ) u_step (
    .op          (op_q),
    .acc         (acc_q),
    .carry       (flags_q.carry),
    .next_acc_c  (step_acc_c),
    .carry_out_c (step_carry_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ACC_ST_IDLE;
      acc_q     <= '0;
      flags_q   <= '{zero: 1'b1, negative: 1'b0, carry: 1'b0};
      op_q      <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    op_d      = op_q;
    rem_d     = rem_q;

    unique case (state_q)
      ACC_ST_IDLE: begin
        if (load_i) begin
          acc_d            = load_data_i;
          flags_d.zero     = (load_data_i == '0);
          flags_d.negative = load_data_i[WIDTH-1];
        end else if (start_i) begin
          op_d    = op_i;
          rem_d   = acc_op_is_shift(op_i) ? count_i : CNT_W'(1);
          state_d = ACC_ST_EXEC;
        end
      end
      ACC_ST_EXEC: begin
        // rem_q==0 only arises from a zero-count shift: spend one idle EXEC cycle.
        if (rem_q == '0) begin
          state_d = ACC_ST_DONE;
        end else begin
          acc_d         = step_acc_c;
          flags_d.carry = step_carry_c;
          rem_d         = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ACC_ST_DONE;
            if (acc_op_updates_zn(op_q)) begin
              flags_d.zero     = (step_acc_c == '0);
              flags_d.negative = step_acc_c[WIDTH-1];
            end
          end
        end
      end
      ACC_ST_DONE: state_d = ACC_ST_IDLE;
      default:     state_d = ACC_ST_IDLE;
    endcase

    // Status outputs are registered versions of the upcoming state.
    busy_d    = (state_d != ACC_ST_IDLE);
    done_d    = (state_d == ACC_ST_DONE);
    illegal_d = (state_d == ACC_ST_DONE) && acc_op_is_illegal(op_q);
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign illegal_o       = illegal_q;
  assign acc_o           = acc_q;
  assign flag_zero_o     = flags_q.zero;
  assign flag_negative_o = flags_q.negative;
  assign flag_carry_o    = flags_q.carry;

endmodule
